icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the datapath fetch port (iren/iaddr/iload/iwait of cpu_ram_if) and the shared RAM read channel.
- A hit returns the instruction in the same cycle with iwait=0, which the hazard unit reads as ihit.
- A miss holds iwait high while an FSM fetches the full line word-by-word from memory, installs it, and then serves the hit.
- flush (fence.i / program load) invalidates all lines.

---
 rtl/icache_direct_if.sv | 27 ++
 rtl/icache_direct.sv | 106 ++++++++++
 tb/tb_icache_direct.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Fetch-port and memory read-channel bundle for the direct-mapped I-cache.
// slave is the cache view; master is the datapath/memory side.
interface icache_direct_if;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  iren, iaddr, flush,
    input  mem_rdata, mem_ready,
    output iload, iwait,
    output mem_req, mem_addr
  );

  modport master (
    output iren, iaddr, flush,
    output mem_rdata, mem_ready,
    input  iload, iwait,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache.
// Misses fill a whole line word-by-word before the hit is served.
module icache_direct #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic             clk,
  input  logic             rst,
  icache_direct_if.slave   bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
  localparam int LINE_W = TAG_W + IDX_W;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [OFF_W-1:0] LAST =
    OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_n;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0]  fill_cnt;
  logic [LINE_W-1:0] base;
  logic              poison;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] base_tag;
  logic             hit;
  logic             miss_start;
  logic             word_done;
  logic             line_done;

  assign offset   = bus.iaddr[2+OFF_W-1:2];
  assign index    = bus.iaddr[2+OFF_W+IDX_W-1:2+OFF_W];
  assign tag      = bus.iaddr[31:32-TAG_W];
  assign base_idx = base[IDX_W-1:0];
  assign base_tag = base[LINE_W-1:IDX_W];

  // A flush in IDLE masks the hit so the fetch waits out the invalidate.
  assign hit = bus.iren & (state == IDLE) & ~bus.flush
             & valid[index] & (tags[index] == tag);

  assign miss_start = (state == IDLE) & bus.iren
                    & ~hit & ~bus.flush;
  assign word_done  = (state == FILL) & bus.mem_ready;
  assign line_done  = word_done & (fill_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (miss_start) state_n = FILL;
      FILL: if (line_done)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.iwait    = bus.iren & ~hit;
    bus.iload    = NOP;
    if (hit) bus.iload = data[index][offset];
    if (state == FILL) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = {base, fill_cnt, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      fill_cnt <= '0;
      poison   <= 1'b0;
    end else begin
      if (bus.flush) valid <= '0;
      if (bus.flush && state == FILL) poison <= 1'b1;
      if (miss_start) fill_cnt <= '0;
      if (word_done) fill_cnt <= fill_cnt + 1'b1;
      // A flush seen anywhere in the fill leaves the line invalid.
      if (line_done) begin
        valid[base_idx] <= ~poison & ~bus.flush;
        poison          <= 1'b0;
        fill_cnt        <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss_start) base <= bus.iaddr[31:2+OFF_W];
    if (word_done)  data[base_idx][fill_cnt] <= bus.mem_rdata;
    if (line_done)  tags[base_idx] <= base_tag;
  end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct with a line-level cache model
// and a 2-cycle-latency memory returning addr ^ A5A5A5A5.
module tb_icache_direct;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  icache_direct_if bus ();

  icache_direct dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference: which 16-byte line each of the 16 slots holds
  bit          m_valid [16];
  logic [27:0] m_line  [16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ KEY;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  int mwait = 0;
  always @(negedge clk) begin
    if (!bus.mem_req) begin
      bus.mem_ready = 1'b0;
      mwait = 0;
    end else if (mwait == 1) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = bus.mem_addr ^ KEY;
      mwait = 0;
    end else begin
      bus.mem_ready = 1'b0;
      mwait = mwait + 1;
    end
  end

  task automatic fetch(input logic [31:0] a);
    int          stall;
    logic [31:0] seen[$];
    bit          exp_hit;
    bit          ok;
    logic [3:0]  idx;
    idx     = a[7:4];
    exp_hit = m_valid[idx] && (m_line[idx] == a[31:4]);
    stall   = 0;
    @(negedge clk);
    bus.iren  = 1'b1;
    bus.iaddr = a;
    #1;
    while (bus.iwait === 1'b1 && stall < 100) begin
      if (bus.mem_req && bus.mem_ready) seen.push_back(bus.mem_addr);
      stall++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (stall != (exp_hit ? 0 : 9)) begin
      errors++;
      $display("FAIL stall a=%h got %0d want %0d",
               a, stall, exp_hit ? 0 : 9);
    end
    checks++;
    if (bus.iload !== mem_word(a)) begin
      errors++;
      $display("FAIL iload a=%h got %h want %h",
               a, bus.iload, mem_word(a));
    end
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_memreq a=%h got %b want 0", a, bus.mem_req);
    end
    if (!exp_hit) begin
      checks++;
      ok = (seen.size() == 4);
      for (int i = 0; i < 4; i++)
        if (ok && seen[i] !== {a[31:4], 4'h0} + 32'(4 * i)) ok = 1'b0;
      if (!ok) begin
        errors++;
        $display("FAIL fill_seq a=%h got %0d words first %h want base %h",
                 a, seen.size(), seen.size() ? seen[0] : 32'hx,
                 {a[31:4], 4'h0});
      end
    end
    m_valid[idx] = 1'b1;
    m_line[idx]  = a[31:4];
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.iren  = 1'b0;
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.iwait !== 1'b0 || bus.iload !== NOP) begin
      errors++;
      $display("FAIL idle got iwait=%b iload=%h want 0/%h",
               bus.iwait, bus.iload, NOP);
    end
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    bus.iren  = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.iren  = 1'b0;
    bus.iaddr = '0;
    bus.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.iwait !== 1'b0 || bus.iload !== NOP ||
        bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset got iwait=%b iload=%h req=%b addr=%h",
               bus.iwait, bus.iload, bus.mem_req, bus.mem_addr);
    end
    bus.iren  = 1'b1;
    bus.iaddr = 32'h100;
    #1;
    checks++;
    if (bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL reset_miss got iwait=%b want 1", bus.iwait);
    end
    bus.iren = 1'b0;
    model_clear();
  endtask

  task automatic test_miss_fill();
    fetch(32'h100);
  endtask

  task automatic test_seq_hits();
    fetch(32'h104);
    fetch(32'h108);
    fetch(32'h10C);
  endtask

  task automatic test_conflict();
    fetch(32'h500);
    fetch(32'h100);
    idle_cycle();
  endtask

  task automatic test_redirect();
    int          stall;
    logic [31:0] seen[$];
    bit          ok;
    logic [31:0] want;
    stall = 0;
    @(negedge clk);
    bus.iren  = 1'b1;
    bus.iaddr = 32'h200;
    #1;
    while (bus.iwait === 1'b1 && stall < 100) begin
      if (bus.mem_req && bus.mem_ready) seen.push_back(bus.mem_addr);
      stall++;
      @(negedge clk);
      if (stall == 3) bus.iaddr = 32'h340;
      #1;
    end
    checks++;
    if (stall != 18) begin
      errors++;
      $display("FAIL redirect_stall got %0d want 18", stall);
    end
    checks++;
    ok = (seen.size() == 8);
    for (int i = 0; i < 8; i++) begin
      want = (i < 4 ? 32'h200 : 32'h340) + 32'(4 * (i % 4));
      if (ok && seen[i] !== want) ok = 1'b0;
    end
    if (!ok) begin
      errors++;
      $display("FAIL redirect_seq got %0d words want 8 (200..20C,340..34C)",
               seen.size());
    end
    checks++;
    if (bus.iload !== mem_word(32'h340)) begin
      errors++;
      $display("FAIL redirect_load got %h want %h",
               bus.iload, mem_word(32'h340));
    end
    m_valid[0] = 1'b1; m_line[0] = 28'h20;
    m_valid[4] = 1'b1; m_line[4] = 28'h34;
    fetch(32'h200);
    fetch(32'h344);
  endtask

  task automatic test_flush();
    int          stall;
    int          fl;
    logic [31:0] seen[$];
    bit          ok;
    fetch(32'h100);
    fetch(32'h100);
    @(negedge clk);
    bus.iren  = 1'b1;
    bus.iaddr = 32'h100;
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_wait got %b want 1", bus.iwait);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL flush_nofill got req=%b iwait=%b want 0/1",
               bus.mem_req, bus.iwait);
    end
    bus.iren = 1'b0;
    model_clear();
    fetch(32'h100);
    flush_pulse();
    stall = 0;
    fl    = 0;
    @(negedge clk);
    bus.iren  = 1'b1;
    bus.iaddr = 32'h108;
    #1;
    while (bus.iwait === 1'b1 && stall < 100) begin
      if (bus.mem_req && bus.mem_ready) seen.push_back(bus.mem_addr);
      stall++;
      @(negedge clk);
      if (fl == 1) begin bus.flush = 1'b0; fl = 2; end
      if (fl == 0 && seen.size() == 2) begin bus.flush = 1'b1; fl = 1; end
      #1;
    end
    checks++;
    if (stall != 18) begin
      errors++;
      $display("FAIL flush_fill_stall got %0d want 18", stall);
    end
    checks++;
    ok = (seen.size() == 8);
    for (int i = 0; i < 8; i++)
      if (ok && seen[i] !== 32'h100 + 32'(4 * (i % 4))) ok = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL flush_fill_seq got %0d words want 8", seen.size());
    end
    checks++;
    if (bus.iload !== mem_word(32'h108)) begin
      errors++;
      $display("FAIL flush_fill_load got %h want %h",
               bus.iload, mem_word(32'h108));
    end
    m_valid[0] = 1'b1;
    m_line[0]  = 28'h10;
  endtask

  task automatic test_reset_mid_fill();
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    @(negedge clk);
    bus.iren  = 1'b1;
    bus.iaddr = 32'h600;
    #1;
    while (n < 1 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.mem_req && bus.mem_ready) n++;
    end
    @(negedge clk);
    rst      = 1'b1;
    bus.iren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || n != 1) begin
      errors++;
      $display("FAIL rst_fill got req=%b words=%0d want 0/1",
               bus.mem_req, n);
    end
    model_clear();
    fetch(32'h340);
    fetch(32'h100);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 40; k++) begin
      a = ($urandom & 32'h0000_07FF) |
          ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0);
      fetch(a);
      if ($urandom_range(0, 2) == 0) idle_cycle();
      if ($urandom_range(0, 9) == 0) flush_pulse();
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_miss_fill();
    test_seq_hits();
    test_conflict();
    test_redirect();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
